ring_decoder: RTL and testbench



---
 rtl/ring_decoder.sv | 105 ++++++++++
 tb/tb_ring_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ring_decoder: decodes a rotating one-hot ring to a position, tracks      |
// | step direction and count, and latches a sticky fault on illegal moves.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ring_decoder #(
  parameter  int WIDTH = 4,
  parameter  int CNT_W = 8,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             sw,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             dir,
  output logic [CNT_W-1:0] step_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [IDX_W-1:0] c_last = IDX_W'(WIDTH - 1);

  state_t           state;
  logic             is_onehot;
  logic [IDX_W-1:0] hot_pos;
  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] idx_dec;
  logic             pat_hold;
  logic             pat_fwd;
  logic             pat_back;

  always_comb begin
    hot_pos = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (ring_in[k]) hot_pos = IDX_W'(k);
    end
    is_onehot = $onehot(ring_in);
    idx_inc   = (idx == c_last) ? '0 : idx + 1'b1;
    idx_dec   = (idx == '0) ? c_last : idx - 1'b1;
    pat_hold  = (ring_in == (c_one << idx));
    pat_fwd   = (ring_in == (c_one << idx_inc));
    pat_back  = (ring_in == (c_one << idx_dec));
  end

  always_ff @(posedge clk) begin
    if (sw) begin
      state    <= SEARCH;
      idx      <= '0;
      valid    <= 1'b0;
      dir      <= 1'b0;
      step_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (is_onehot) begin
            idx   <= hot_pos;
            valid <= 1'b1;
            dir   <= 1'b0;
            state <= LOCK;
          end else begin
            valid <= 1'b0;
            err   <= 1'b0;
          end
        end
        LOCK: begin
          // Hold is tested first so a stationary ring never counts as a step.
          if (pat_hold) begin
            state <= LOCK;
          end else if (pat_fwd) begin
            idx      <= idx_inc;
            dir      <= 1'b1;
            step_cnt <= step_cnt + CNT_W'(1);
          end else if (pat_back) begin
            idx      <= idx_dec;
            dir      <= 1'b0;
            step_cnt <= step_cnt + CNT_W'(1);
          end else begin
            err   <= 1'b1;
            valid <= 1'b0;
            state <= FAULT;
          end
        end
        FAULT: begin
          err   <= 1'b1;
          valid <= 1'b0;
        end
        default: begin
          state <= SEARCH;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ring_decoder: directed and randomized checks of ring_decoder against  |
// | a behavioural model (two instances: 8-bit and 3-bit step counters).      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ring_decoder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         sw = 1'b1;
  logic [W-1:0] ring_in = '0;

  logic [1:0] idx_a, idx_b;
  logic       valid_a, valid_b, dir_a, dir_b, err_a, err_b;
  logic [7:0] cnt_a;
  logic [2:0] cnt_b;

  ring_decoder #(.WIDTH(W), .CNT_W(8)) dut_a (
    .clk(clk), .sw(sw), .ring_in(ring_in), .idx(idx_a), .valid(valid_a),
    .dir(dir_a), .step_cnt(cnt_a), .err(err_a)
  );

  ring_decoder #(.WIDTH(W), .CNT_W(3)) dut_b (
    .clk(clk), .sw(sw), .ring_in(ring_in), .idx(idx_b), .valid(valid_b),
    .dir(dir_b), .step_cnt(cnt_b), .err(err_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 = hunting for a ring, 1 = following it, 2 = faulted.
  int mode = 0;
  int m_idx = 0;
  int m_steps = 0;
  bit m_valid = 0, m_dir = 0, m_err = 0;

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic bit is_pos(input logic [W-1:0] r, input int p);
    return r == (W'(1) << p);
  endfunction

  task automatic model_update(input bit s, input logic [W-1:0] r);
    if (s) begin
      mode = 0; m_idx = 0; m_steps = 0; m_valid = 0; m_dir = 0; m_err = 0;
    end else if (mode == 0) begin
      if ($countones(r) == 1) begin
        for (int k = 0; k < W; k++) if (r[k]) m_idx = k;
        m_valid = 1; m_dir = 0; mode = 1;
      end
    end else if (mode == 1) begin
      if (is_pos(r, m_idx)) begin
        // stationary
      end else if (is_pos(r, (m_idx + 1) % W)) begin
        m_idx = (m_idx + 1) % W; m_dir = 1; m_steps++;
      end else if (is_pos(r, (m_idx + W - 1) % W)) begin
        m_idx = (m_idx + W - 1) % W; m_dir = 0; m_steps++;
      end else begin
        m_err = 1; m_valid = 0; mode = 2;
      end
    end
  endtask

  task automatic compare_all();
    chk("idx_a", int'(idx_a), m_idx);
    chk("valid_a", int'(valid_a), int'(m_valid));
    chk("dir_a", int'(dir_a), int'(m_dir));
    chk("cnt_a", int'(cnt_a), m_steps % 256);
    chk("err_a", int'(err_a), int'(m_err));
    chk("idx_b", int'(idx_b), m_idx);
    chk("valid_b", int'(valid_b), int'(m_valid));
    chk("dir_b", int'(dir_b), int'(m_dir));
    chk("cnt_b", int'(cnt_b), m_steps % 8);
    chk("err_b", int'(err_b), int'(m_err));
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic cyc(input bit s, input logic [W-1:0] r);
    sw = s;
    ring_in = r;
    @(posedge clk);
    model_update(s, r);
    #1;
    compare_all();
  endtask

  initial begin
    logic [W-1:0] r;
    int p;

    // Reset with a multi-hot pattern present.
    cyc(1, 4'b0101);
    cyc(1, 4'b0101);
    chk("rst_idx", int'(idx_a), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    cyc(0, 4'b0101);
    chk("rst_still_search", int'(valid_a), 0);

    // Forward wrap.
    cyc(1, 4'b0000);
    cyc(0, 4'b0001); chk("fwd_idx0", int'(idx_a), 0); chk("fwd_valid0", int'(valid_a), 1);
    cyc(0, 4'b0010); chk("fwd_idx1", int'(idx_a), 1); chk("fwd_dir1", int'(dir_a), 1);
    cyc(0, 4'b0100); chk("fwd_idx2", int'(idx_a), 2);
    cyc(0, 4'b1000); chk("fwd_idx3", int'(idx_a), 3);
    cyc(0, 4'b0001); chk("fwd_idx_wrap", int'(idx_a), 0);
    chk("fwd_cnt", int'(cnt_a), 4);
    chk("fwd_err", int'(err_a), 0);

    // Backward wrap plus holds.
    cyc(1, 4'b0000);
    cyc(0, 4'b0001);
    cyc(0, 4'b1000); chk("back_idx3", int'(idx_a), 3);
    cyc(0, 4'b1000);
    cyc(0, 4'b1000);
    cyc(0, 4'b0100); chk("back_idx2", int'(idx_a), 2);
    chk("back_dir", int'(dir_a), 0);
    chk("back_cnt", int'(cnt_a), 2);

    // Search rejects zero and multi-hot.
    cyc(1, 4'b0000);
    cyc(0, 4'b0000);
    cyc(0, 4'b0011);
    cyc(0, 4'b1111);
    chk("srch_valid", int'(valid_a), 0);
    chk("srch_err", int'(err_a), 0);
    cyc(0, 4'b0100);
    chk("srch_lock_idx", int'(idx_a), 2);
    chk("srch_lock_valid", int'(valid_a), 1);
    chk("srch_lock_cnt", int'(cnt_a), 0);

    // Jump of two positions faults; fault is sticky until reset.
    cyc(1, 4'b0000);
    cyc(0, 4'b0001);
    cyc(0, 4'b0100);
    chk("flt_err", int'(err_a), 1);
    chk("flt_valid", int'(valid_a), 0);
    chk("flt_idx", int'(idx_a), 0);
    cyc(0, 4'b0001);
    cyc(0, 4'b0010);
    chk("flt_sticky", int'(err_a), 1);
    cyc(1, 4'b0010);
    chk("flt_clear_err", int'(err_a), 0);
    chk("flt_clear_valid", int'(valid_a), 0);

    // Nine forward steps: 3-bit counter wraps to 1.
    cyc(1, 4'b0000);
    cyc(0, 4'b0001);
    for (int i = 1; i <= 9; i++) begin
      r = W'(1) << (i % W);
      cyc(0, r);
    end
    chk("wrap_cnt3", int'(cnt_b), 1);
    chk("wrap_idx", int'(idx_b), 1);
    chk("wrap_cnt8", int'(cnt_a), 9);
    chk("wrap_err", int'(err_b), 0);

    // Randomized mix of holds, steps, illegal patterns and resets.
    for (int n = 0; n < 3000; n++) begin
      p = int'($urandom_range(0, 99));
      if (p < 3) begin
        cyc(1, W'($urandom));
      end else if (p < 6 || mode != 1) begin
        cyc(0, W'($urandom));
      end else if (p < 30) begin
        r = W'(1) << m_idx;
        cyc(0, r);
      end else if (p < 70) begin
        r = W'(1) << ((m_idx + 1) % W);
        cyc(0, r);
      end else begin
        r = W'(1) << ((m_idx + W - 1) % W);
        cyc(0, r);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
